// File: rtl/xocc_dsa_share_arbiter.sv
// xocc_dsa_share_arbiter: round-robin sharing of one DSA among N_CH XOCC channels, one command in flight
module xocc_dsa_share_arbiter #(
    parameter int N_CH  = 2,
    parameter int CMD_W = 32,
    parameter int RSP_W = 32,
    localparam int GW   = N_CH > 1 ? $clog2(N_CH) : 1
) (
    input  logic                    xocc_clk,
    input  logic                    xocc_rst,
    input  logic [N_CH-1:0]         ch_cmd_empty,
    input  logic [N_CH*CMD_W-1:0]   ch_cmd_buffer,
    output logic [N_CH-1:0]         ch_cmd_rd_en,
    input  logic [N_CH-1:0]         ch_rsp_full,
    output logic [N_CH*RSP_W-1:0]   ch_rsp_buffer,
    output logic [N_CH-1:0]         ch_rsp_wr_en,
    output logic                    dsa_cmd_valid,
    input  logic                    dsa_cmd_ready,
    output logic [CMD_W-1:0]        dsa_cmd_data,
    input  logic                    dsa_rsp_valid,
    output logic                    dsa_rsp_ready,
    input  logic [RSP_W-1:0]        dsa_rsp_data,
    output logic [GW-1:0]           grant_id,
    output logic                    busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, WRITE} state_t;
    state_t state, state_n;
    logic [GW-1:0] last_grant, sel, idx;
    logic found;
    logic [CMD_W-1:0] cmd_q;
    logic [RSP_W-1:0] rsp_q;
    logic [N_CH-1:0] req;
    assign req = ~ch_cmd_empty;
    // scan downward in offset so the nearest requester after last_grant is the final assignment
    always_comb begin
        sel = '0;
        idx = '0;
        found = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = GW'((int'(last_grant) + 1 + i) % N_CH);
            if (req[idx]) begin
                sel = idx;
                found = 1'b1;
            end
        end
    end
    // reset masks the pulses so a handshake coinciding with reset has no effect
    always_comb begin
        ch_cmd_rd_en = '0;
        ch_rsp_wr_en = '0;
        for (int i = 0; i < N_CH; i++) begin
            ch_cmd_rd_en[i] = !xocc_rst && state == IDLE && found && sel == GW'(i);
            ch_rsp_wr_en[i] = !xocc_rst && state == WRITE && !ch_rsp_full[i] && grant_id == GW'(i);
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = found ? ISSUE : IDLE;
            ISSUE:    state_n = dsa_cmd_ready ? WAIT_RSP : ISSUE;
            WAIT_RSP: state_n = dsa_rsp_valid ? WRITE : WAIT_RSP;
            WRITE:    state_n = |ch_rsp_wr_en ? IDLE : WRITE;
            default:  state_n = IDLE;
        endcase
    end
    always_ff @(posedge xocc_clk) begin
        if (xocc_rst) begin
            state <= IDLE;
            last_grant <= GW'(N_CH - 1);
            grant_id <= '0;
            cmd_q <= '0;
            rsp_q <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && found) begin
                grant_id <= sel;
                last_grant <= sel;
                cmd_q <= ch_cmd_buffer[int'(sel) * CMD_W +: CMD_W];
            end
            if (state == WAIT_RSP && dsa_rsp_valid) rsp_q <= dsa_rsp_data;
        end
    end
    assign busy = state != IDLE;
    assign dsa_cmd_valid = state == ISSUE;
    assign dsa_rsp_ready = state == WAIT_RSP;
    assign dsa_cmd_data = cmd_q;
    assign ch_rsp_buffer = {N_CH{rsp_q}};
endmodule

// File: tb/tb_xocc_dsa_share_arbiter.sv
// tb_xocc_dsa_share_arbiter: FIFO/DSA models around a 2-channel and a 4-channel arbiter
module tb_xocc_dsa_share_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, rst4;
    logic [1:0] cmd_empty, rd_en, rsp_full, wr_en;
    logic [63:0] cmd_buf, rsp_buf;
    logic cv, cr, rv, rr, busy;
    logic [0:0] gid;
    logic [31:0] cd, rd;
    logic [3:0] e4, rd4, full4, wr4;
    logic [127:0] buf4, rbuf4;
    logic cv4, rr4, busy4;
    logic [31:0] cd4;
    logic [1:0] gid4;

    xocc_dsa_share_arbiter #(.N_CH(2), .CMD_W(32), .RSP_W(32)) u2 (
        .xocc_clk(clk), .xocc_rst(rst),
        .ch_cmd_empty(cmd_empty), .ch_cmd_buffer(cmd_buf), .ch_cmd_rd_en(rd_en),
        .ch_rsp_full(rsp_full), .ch_rsp_buffer(rsp_buf), .ch_rsp_wr_en(wr_en),
        .dsa_cmd_valid(cv), .dsa_cmd_ready(cr), .dsa_cmd_data(cd),
        .dsa_rsp_valid(rv), .dsa_rsp_ready(rr), .dsa_rsp_data(rd),
        .grant_id(gid), .busy(busy)
    );

    xocc_dsa_share_arbiter #(.N_CH(4), .CMD_W(32), .RSP_W(32)) u4 (
        .xocc_clk(clk), .xocc_rst(rst4),
        .ch_cmd_empty(e4), .ch_cmd_buffer(buf4), .ch_cmd_rd_en(rd4),
        .ch_rsp_full(full4), .ch_rsp_buffer(rbuf4), .ch_rsp_wr_en(wr4),
        .dsa_cmd_valid(cv4), .dsa_cmd_ready(1'b1), .dsa_cmd_data(cd4),
        .dsa_rsp_valid(1'b1), .dsa_rsp_ready(rr4), .dsa_rsp_data(32'h0),
        .grant_id(gid4), .busy(busy4)
    );

    int total, bad, cyc, rd_cnt, wr_cnt, rd_cyc, wr_cyc, acc_cyc, stall_cnt;
    int cr_block, full_req, full_block, r0;
    bit pend, stray, no_rsp, prev_hold;
    logic [31:0] pend_d, prev_cd, last_cmd, last_rsp;
    logic [31:0] cq0[$], cq1[$], cmdq[$];
    logic [32:0] sb[$];
    int eg[$], g4[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: drive models, sample mid-cycle, score, then advance past the edge
    task automatic tick();
        logic [32:0] e;
        logic [31:0] d;
        int g;
        cmd_empty = {cq1.size() == 0, cq0.size() == 0};
        cmd_buf = {cq1.size() != 0 ? cq1[0] : 32'h0, cq0.size() != 0 ? cq0[0] : 32'h0};
        rv = (pend && !no_rsp) || stray;
        rd = pend ? pend_d : 32'hDEAD_BEEF;
        cr = cr_block == 0;
        rsp_full = {full_block > 0, 1'b0};
        #4;
        if (prev_hold) chk("cmd_hold", {cv, cd}, {1'b1, prev_cd});
        prev_hold = cv && !cr;
        prev_cd = cd;
        if (cv && !cr) begin
            stall_cnt++;
            cr_block--;
        end
        if (stray) chk("stray_rdy", rr, 0);
        if (rsp_full[1]) begin
            full_block--;
            chk("full_no_wr", wr_en, 0);
        end
        if (rd_en != 0) begin
            g = int'(rd_en[1]);
            chk("rd_onehot", $onehot(rd_en), 1);
            chk("grant_expected", eg.size() != 0, 1);
            if (eg.size() != 0) chk("grant", g, eg.pop_front());
            chk("pop_nonempty", (g == 1 ? cq1.size() : cq0.size()) != 0, 1);
            d = 32'h0;
            if (g == 1 && cq1.size() != 0) d = cq1.pop_front();
            if (g == 0 && cq0.size() != 0) d = cq0.pop_front();
            cmdq.push_back(d);
            sb.push_back({rd_en[1], d + 32'h1});
            rd_cnt++;
            rd_cyc = cyc;
        end
        if (rv && rr && pend) begin
            pend = 0;
            acc_cyc = cyc;
            if (full_req > 0) begin
                full_block = full_req;
                full_req = 0;
            end
        end
        if (cv && cr) begin
            chk("cmd_expected", cmdq.size() != 0, 1);
            if (cmdq.size() != 0) chk("cmd_data", cd, cmdq.pop_front());
            pend = 1;
            pend_d = cd + 32'h1;
            last_cmd = cd;
        end
        if (wr_en != 0) begin
            chk("wr_onehot", $onehot(wr_en), 1);
            chk("wr_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rsp_ch", wr_en, e[32] ? 2'b10 : 2'b01);
                chk("rsp_data", e[32] ? rsp_buf[63:32] : rsp_buf[31:0], e[31:0]);
            end
            last_rsp = rsp_buf[31:0];
            wr_cnt++;
            wr_cyc = cyc;
        end
        if (rd4 != 0) begin
            chk("rd4_sparse", rd4[0] | rd4[2], 0);
            g4.push_back(rd4[3] ? 3 : rd4[2] ? 2 : rd4[1] ? 1 : 0);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_wr(input int n);
        for (int k = 0; k < 100 && wr_cnt < n; k++) tick();
        chk("wr_count", wr_cnt, n);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; rd_cnt = 0; wr_cnt = 0;
        rd_cyc = 0; wr_cyc = 0; acc_cyc = 0; stall_cnt = 0;
        cr_block = 0; full_req = 0; full_block = 0;
        pend = 0; stray = 0; no_rsp = 0; prev_hold = 0;
        pend_d = '0; prev_cd = '0; last_cmd = '0; last_rsp = '0;
        rst = 1'b1; rst4 = 1'b1;
        e4 = 4'b0101; buf4 = '0; full4 = '0;
        tick();
        tick();
        chk("rst_outs", {rd_en, wr_en, cv, rr, cd, gid, busy}, 0);
        chk("rst_rsp_buf", rsp_buf, 0);
        // round-robin with both channels loaded; pushed while still in reset
        for (int i = 0; i < 3; i++) begin
            cq0.push_back(32'h1000_0000 + 32'(i));
            cq1.push_back(32'h2000_0000 + 32'(i));
            eg.push_back(0);
            eg.push_back(1);
        end
        tick();
        chk("rst_rd_en", rd_en, 0);
        rst = 1'b0;
        wait_wr(6);
        chk("rr_grants_left", eg.size(), 0);
        // single command on ch0
        cq0.push_back(32'hA5A5_0001);
        eg.push_back(0);
        wait_wr(7);
        chk("single_rd_cnt", rd_cnt, 7);
        chk("single_cmd", last_cmd, 32'hA5A5_0001);
        chk("single_rsp", last_rsp, 32'hA5A5_0002);
        chk("single_lat", wr_cyc - rd_cyc, 3);
        chk("single_idle", busy, 0);
        // single requester regranted back-to-back
        cq0.push_back(32'h3000_0000);
        cq0.push_back(32'h3000_0001);
        eg.push_back(0);
        eg.push_back(0);
        tick();
        r0 = rd_cyc;
        wait_wr(9);
        chk("regrant_gap", rd_cyc - r0, 4);
        // command and response backpressure on ch1
        cr_block = 5; full_req = 7; stall_cnt = 0;
        cq1.push_back(32'h4000_0000);
        eg.push_back(1);
        wait_wr(10);
        chk("bp_stall", stall_cnt, 5);
        chk("bp_full_lat", wr_cyc - acc_cyc, 8);
        tick();
        tick();
        chk("bp_one_pulse", wr_cnt, 10);
        // stray responses in IDLE and ISSUE
        stray = 1; tick(); stray = 0;
        chk("stray_idle_busy", busy, 0);
        cq0.push_back(32'h5000_0000);
        eg.push_back(0);
        cr_block = 2;
        tick();
        stray = 1; tick(); stray = 0;
        chk("stray_issue_valid", cv, 1);
        wait_wr(11);
        chk("stray_rsp", last_rsp, 32'h5000_0001);
        // reset while waiting for the DSA, coinciding with its response
        no_rsp = 1;
        cq0.push_back(32'h6000_0000);
        eg.push_back(0);
        tick();
        tick();
        tick();
        chk("mid_wait", rr, 1);
        rst = 1'b1; no_rsp = 0;
        tick();
        rst = 1'b0;
        chk("rst_mid_outs", {rd_en, wr_en, cv, rr, cd, gid, busy}, 0);
        chk("rst_mid_buf", rsp_buf, 0);
        sb.delete();
        cmdq.delete();
        pend = 0;
        cq1.push_back(32'h7000_0000);
        cq0.push_back(32'h7100_0000);
        eg.push_back(0);
        eg.push_back(1);
        wait_wr(13);
        chk("rst_grants_left", eg.size(), 0);
        // four channels, only ch1 and ch3 requesting
        rst4 = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        chk("g4_count", g4.size() >= 4, 1);
        for (int k = 0; k < 4; k++)
            chk("g4_order", g4.size() > k ? g4[k] : -1, (k % 2 == 1) ? 3 : 1);
        chk("final_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
